// File: rtl/memory_responder_if.sv
// memory_responder_if: processor-side strobe/address/data bus of a paged byte memory
interface memory_responder_if;
    logic       b_AS_L;
    logic       b_RW;
    logic [7:0] b_Bus_in;
    logic [7:0] b_Bus_out;
    logic       b_Bus_oe;
    logic       b_dValid_L;
    modport master (output b_AS_L, b_RW, b_Bus_in, input b_Bus_out, b_Bus_oe, b_dValid_L);
    modport slave (input b_AS_L, b_RW, b_Bus_in, output b_Bus_out, b_Bus_oe, b_dValid_L);
endinterface

// File: rtl/memory_responder.sv
// memory_responder: byte memory answering one 16 KiB page of a strobed two-byte-address bus
module memory_responder #(
    parameter logic [1:0] PAGE  = 2'b01,
    parameter int         DEPTH = 16384
) (
    input logic b_Clock,
    input logic b_Reset_L,
    memory_responder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LO_SEL, LO_SKIP, WDATA, RDATA, SKIP_DATA} state_t;
    state_t      state;
    logic [5:0]  upper;
    logic [7:0]  lower;
    logic        rw;
    logic [13:0] addr;
    logic [7:0]  mem [DEPTH];
    assign addr = {upper, lower};
    // The array has no reset so its contents survive b_Reset_L.
    always_ff @(posedge b_Clock)
        if (b_Reset_L && state == WDATA) mem[addr] <= bus.b_Bus_in;
    // Read data is registered out of RDATA, so it is valid for the cycle following it.
    always_ff @(posedge b_Clock or negedge b_Reset_L)
        if (!b_Reset_L) begin
            state          <= IDLE;
            upper          <= '0;
            lower          <= '0;
            rw             <= 1'b0;
            bus.b_dValid_L <= 1'b1;
            bus.b_Bus_oe   <= 1'b0;
            bus.b_Bus_out  <= 8'h00;
        end else begin
            bus.b_dValid_L <= state != RDATA;
            bus.b_Bus_oe   <= state == RDATA;
            bus.b_Bus_out  <= state == RDATA ? mem[addr] : 8'h00;
            case (state)
                IDLE: if (!bus.b_AS_L) begin
                    upper <= bus.b_Bus_in[5:0];
                    rw    <= bus.b_RW;
                    state <= bus.b_Bus_in[7:6] == PAGE ? LO_SEL : LO_SKIP;
                end
                LO_SEL: if (!bus.b_AS_L) begin
                    lower <= bus.b_Bus_in;
                    state <= rw ? RDATA : WDATA;
                end
                LO_SKIP: if (!bus.b_AS_L) state <= SKIP_DATA;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: two pages on one bus, directed writes/reads with hand-computed results
module tb_memory_responder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       as_l = 1'b1;
    logic       rw = 1'b0;
    logic [7:0] din = 8'h00;
    int checks = 0, errors = 0;
    int dv0 = 0, dv1 = 0, oe0 = 0, oe1 = 0, both = 0;
    int exp_r0 = 0, exp_r1 = 0;

    always #5 clk = ~clk;

    memory_responder_if if0();
    memory_responder_if if1();
    assign if0.b_AS_L = as_l;
    assign if0.b_RW = rw;
    assign if0.b_Bus_in = din;
    assign if1.b_AS_L = as_l;
    assign if1.b_RW = rw;
    assign if1.b_Bus_in = din;

    memory_responder #(.PAGE(2'b01)) u0 (.b_Clock(clk), .b_Reset_L(rst_n), .bus(if0));
    memory_responder #(.PAGE(2'b10)) u1 (.b_Clock(clk), .b_Reset_L(rst_n), .bus(if1));

    always @(negedge clk) begin
        if (!if0.b_dValid_L) dv0++;
        if (!if1.b_dValid_L) dv1++;
        if (if0.b_Bus_oe) oe0++;
        if (if1.b_Bus_oe) oe1++;
        if (if0.b_Bus_oe && if1.b_Bus_oe) both++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the data cycle.
    task automatic wr(input logic [15:0] a, input logic [7:0] d, input int gap);
        as_l = 1'b0; rw = 1'b0; din = a[15:8]; @(negedge clk);
        as_l = 1'b1; din = 8'h00; repeat (gap) @(negedge clk);
        as_l = 1'b0; din = a[7:0]; @(negedge clk);
        as_l = 1'b1; din = d; @(negedge clk);
        din = 8'h00;
    endtask

    // sel: 0 = page-01 instance answers, 1 = page-10 instance answers, 2 = nobody answers
    task automatic rd(input string tag, input logic [15:0] a, input int gap, input int sel, input logic [7:0] exp);
        int s0, s1, so;
        as_l = 1'b0; rw = 1'b1; din = a[15:8]; @(negedge clk);
        as_l = 1'b1; din = 8'h00; repeat (gap) @(negedge clk);
        as_l = 1'b0; din = a[7:0]; @(negedge clk);
        as_l = 1'b1; din = 8'h00;
        if (sel == 2) begin
            s0 = dv0; s1 = dv1; so = oe0 + oe1;
            repeat (25) @(negedge clk);
            #1;
            chk({tag, "_dv0"}, dv0 - s0, 0);
            chk({tag, "_dv1"}, dv1 - s1, 0);
            chk({tag, "_oe"}, oe0 + oe1 - so, 0);
        end else begin
            if (sel == 0) exp_r0++; else exp_r1++;
            chk({tag, "_early"}, sel == 0 ? if0.b_dValid_L : if1.b_dValid_L, 1);
            @(negedge clk);
            chk({tag, "_dv"}, sel == 0 ? if0.b_dValid_L : if1.b_dValid_L, 0);
            chk({tag, "_oe"}, sel == 0 ? if0.b_Bus_oe : if1.b_Bus_oe, 1);
            chk({tag, "_data"}, sel == 0 ? if0.b_Bus_out : if1.b_Bus_out, exp);
            @(negedge clk);
            chk({tag, "_dv_end"}, sel == 0 ? if0.b_dValid_L : if1.b_dValid_L, 1);
            chk({tag, "_oe_end"}, sel == 0 ? if0.b_Bus_oe : if1.b_Bus_oe, 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dv0", if0.b_dValid_L, 1);
        chk("rst_oe0", if0.b_Bus_oe, 0);
        chk("rst_out0", if0.b_Bus_out, 8'h00);
        chk("rst_oe1", if1.b_Bus_oe, 0);
        rst_n = 1'b1;
        @(negedge clk);
        wr(16'h7F11, 8'hAB, 1);
        wr(16'h7F22, 8'hCD, 1);
        wr(16'h7E11, 8'hEF, 1);
        rd("r7F11", 16'h7F11, 1, 0, 8'hAB);
        rd("r7F22", 16'h7F22, 1, 0, 8'hCD);
        rd("r7E11", 16'h7E11, 1, 0, 8'hEF);
        wr(16'hBF11, 8'hCD, 2);
        rd("p01", 16'h7F11, 2, 0, 8'hAB);
        rd("p10", 16'hBF11, 2, 1, 8'hCD);
        wr(16'h7F11, 8'hAB, 20);
        rd("gap20", 16'h7F11, 20, 0, 8'hAB);
        wr(16'h7F11, 8'h43, 0);
        wr(16'h7E11, 8'h78, 0);
        rd("gap0_a", 16'h7F11, 0, 0, 8'h43);
        rd("gap0_b", 16'h7E11, 0, 0, 8'h78);
        wr(16'h3F11, 8'h27, 0);
        rd("page00", 16'h3F11, 0, 2, 8'h00);
        rd("after00", 16'h7F11, 0, 0, 8'h43);
        as_l = 1'b0; rw = 1'b0; din = 8'h7F; @(negedge clk);
        as_l = 1'b1; din = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_dv0", if0.b_dValid_L, 1);
        chk("midrst_oe0", if0.b_Bus_oe, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        rd("after_rst", 16'h7F11, 1, 0, 8'h43);
        #1;
        chk("tot_dv0", dv0, exp_r0);
        chk("tot_oe0", oe0, exp_r0);
        chk("tot_dv1", dv1, exp_r1);
        chk("tot_oe1", oe1, exp_r1);
        chk("overlap", both, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter PAGE, default 2'b01: page this instance answers, compared against addr[15:14].
REQ-002 Parameter DEPTH, default 16384: bytes stored, indexed by addr[13:0].
REQ-003 b_Clock  in  1  single clock; all state updates on its rising edge.
REQ-004 b_Reset_L  in  1  reset, asynchronous and active-low.
REQ-005 b_AS_L  in  1  address strobe from processor, active-low, one cycle per address byte.
REQ-006 b_RW  in  1  1=read, 0=write; sampled with the upper-address strobe only.
REQ-007 b_Bus_in  in  8  address or write-data byte from processor.
REQ-008 b_Bus_out  out  8  read-data byte driven by this memory.
REQ-009 b_Bus_oe  out  1  high while b_Bus_out is valid; processor or bus logic tristates on it.
REQ-010 b_dValid_L  out  1  read data valid, active-low, one cycle.

Function
REQ-011 The transaction SHALL consist of three phases: first b_AS_L low with upper address byte, then a gap of 0 or more cycles with b_AS_L high, then b_AS_L low with lower address byte.
REQ-012 For a write, the data byte SHALL be on b_Bus_in in the cycle immediately after the lower-address strobe.
REQ-013 The FSM SHALL use states IDLE, LO_SEL, LO_SKIP, WDATA, RDATA and SKIP_DATA.
REQ-014 In IDLE with b_AS_L low, the block SHALL latch the upper byte and b_RW; it SHALL go to LO_SEL if b_Bus_in[7:6]==PAGE, otherwise to LO_SKIP.
REQ-015 LO_SEL and LO_SKIP SHALL wait without limit while b_AS_L is high; no timeout exists in this block.
REQ-016 LO_SEL with b_AS_L low SHALL latch the lower byte and go to WDATA (write) or RDATA (read).
REQ-017 LO_SKIP with b_AS_L low SHALL go to SKIP_DATA.
REQ-018 WDATA SHALL write b_Bus_in to mem[{upper[5:0],lower}] at that edge, then go to IDLE.
REQ-019 RDATA SHALL drive b_dValid_L=0, b_Bus_oe=1 and b_Bus_out=mem[addr] for exactly one cycle, then go to IDLE.
REQ-020 Read latency: the lower strobe is sampled at edge N; data is valid between edges N+1 and N+2 and is sampled by the processor at edge N+2.
REQ-021 SKIP_DATA SHALL consume one cycle, drive nothing and write nothing, then go to IDLE, so that a non-selected memory stays aligned with the protocol.
REQ-022 b_AS_L SHALL be ignored in WDATA, RDATA and SKIP_DATA; those cycles are treated as data cycles regardless.
REQ-023 Back-to-back transactions: an upper strobe in the cycle right after WDATA, RDATA or SKIP_DATA SHALL be accepted.
REQ-024 b_Bus_oe and b_dValid_L SHALL never be active outside RDATA.
REQ-025 When multiple instances have distinct PAGE, at most one SHALL drive the bus per transaction.
REQ-026 An access to a page with no instance SHALL cause no instance to respond; the processor timeout handles this case.

Reset
REQ-027 When b_Reset_L is low, the block SHALL asynchronously set state=IDLE, b_dValid_L=1, b_Bus_oe=0, b_Bus_out=8'h00 and clear the latched address.
REQ-028 Reset SHALL NOT clear array contents; data written before a reset SHALL read back unchanged after it.
REQ-029 Reset asserted mid-transaction (any state) SHALL abort it: no write, no response, and the block SHALL restart in IDLE.

Verification
REQ-030 PAGE=01: write 7F11=AB, 7F22=CD, 7E11=EF, then read each -> returns AB, CD, EF with b_dValid_L low exactly one cycle per read.
REQ-031 Instances PAGE=01 and PAGE=10: write 7F11=AB and BF11=CD, then read both -> AB from the 01 instance and CD from the 10 instance; the other instance's b_Bus_oe stays 0 throughout.
REQ-032 Gap of 20 cycles between upper and lower strobes: write 7F11=AB then read -> AB returned; no spurious b_dValid_L during the gap.
REQ-033 Zero gap: write 7F11=43, write 7E11=78, read 7F11 -> 43, with latency per REQ-020.
REQ-034 Access to 3F11 (page 00): write 27, then read -> b_dValid_L stays 1 for 25 cycles; the next access to 7F11 reads 43 correctly.
REQ-035 Reset pulsed while in LO_SEL of a write to 7F11=99 -> no write occurs; a subsequent read of 7F11 returns 43.
